// File: rtl/game_state_bank.sv
// Double-buffered game-state store between the game logic and the VGA draw path.
// The shadow copy is written freely; the active copy only moves on frame-aligned swaps.
module game_state_bank #(
    parameter int NUM_PLATS = 4,
    parameter int COLOR_W   = 3,
    parameter int POS_W     = 7,
    parameter int BALL_W    = 8,
    parameter int SCORE_W   = 12,
    parameter logic [COLOR_W-1:0] BALL_COLOR_INIT = 3'b111,
    parameter logic [NUM_PLATS*COLOR_W-1:0] PLAT_COLOR_INIT = 12'b001110111101
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           restart,
    input  logic                           wr_ball,
    input  logic [BALL_W-1:0]              ball_in,
    input  logic                           wr_ball_color,
    input  logic [COLOR_W-1:0]             ball_color_in,
    input  logic [NUM_PLATS-1:0]           wr_plat,
    input  logic [NUM_PLATS*COLOR_W-1:0]   plat_color_in,
    input  logic [NUM_PLATS*POS_W-1:0]     plat_pos_in,
    input  logic                           score_add,
    input  logic [3:0]                     score_amt,
    input  logic                           commit,
    input  logic                           frame_tick,
    output logic [BALL_W-1:0]              prev_ball_out,
    output logic [BALL_W-1:0]              curr_ball_out,
    output logic [COLOR_W-1:0]             ball_color_out,
    output logic [NUM_PLATS*COLOR_W-1:0]   plat_color_out,
    output logic [NUM_PLATS*POS_W-1:0]     plat_pos_out,
    output logic [SCORE_W-1:0]             score_out,
    output logic [SCORE_W-1:0]             high_score_out,
    output logic                           commit_pending,
    output logic                           swapped
);

    logic [BALL_W-1:0]            sh_ball;
    logic [COLOR_W-1:0]           sh_ball_color;
    logic [NUM_PLATS*COLOR_W-1:0] sh_plat_color;
    logic [NUM_PLATS*POS_W-1:0]   sh_plat_pos;
    logic [SCORE_W-1:0]           sh_score;

    logic                         swap;
    logic [SCORE_W:0]             score_sum;
    logic [SCORE_W-1:0]           score_next;

    assign swap = frame_tick & (commit_pending | commit);

    // Extra carry bit lets the add saturate instead of wrapping.
    assign score_sum  = {1'b0, sh_score} + {{(SCORE_W-3){1'b0}}, score_amt};
    assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_ball        <= '0;
            sh_ball_color  <= BALL_COLOR_INIT;
            sh_plat_color  <= PLAT_COLOR_INIT;
            sh_plat_pos    <= '0;
            sh_score       <= '0;
            prev_ball_out  <= '0;
            curr_ball_out  <= '0;
            ball_color_out <= BALL_COLOR_INIT;
            plat_color_out <= PLAT_COLOR_INIT;
            plat_pos_out   <= '0;
            score_out      <= '0;
            high_score_out <= '0;
            commit_pending <= 1'b0;
            swapped        <= 1'b0;
        end else if (restart) begin
            sh_ball        <= '0;
            sh_ball_color  <= BALL_COLOR_INIT;
            sh_plat_color  <= PLAT_COLOR_INIT;
            sh_plat_pos    <= plat_pos_in;
            sh_score       <= '0;
            prev_ball_out  <= curr_ball_out;
            curr_ball_out  <= '0;
            ball_color_out <= BALL_COLOR_INIT;
            plat_color_out <= PLAT_COLOR_INIT;
            plat_pos_out   <= plat_pos_in;
            score_out      <= '0;
            commit_pending <= 1'b0;
            swapped        <= 1'b0;
        end else begin
            if (wr_ball)       sh_ball       <= ball_in;
            if (wr_ball_color) sh_ball_color <= ball_color_in;
            if (score_add)     sh_score      <= score_next;
            for (int i = 0; i < NUM_PLATS; i++) begin
                if (wr_plat[i]) begin
                    sh_plat_color[i*COLOR_W +: COLOR_W] <= plat_color_in[i*COLOR_W +: COLOR_W];
                    sh_plat_pos[i*POS_W +: POS_W]       <= plat_pos_in[i*POS_W +: POS_W];
                end
            end
            // Active side takes the pre-edge shadow, so same-cycle writes wait for the next swap.
            if (swap) begin
                prev_ball_out  <= curr_ball_out;
                curr_ball_out  <= sh_ball;
                ball_color_out <= sh_ball_color;
                plat_color_out <= sh_plat_color;
                plat_pos_out   <= sh_plat_pos;
                score_out      <= sh_score;
                if (sh_score > high_score_out) high_score_out <= sh_score;
            end
            commit_pending <= swap ? 1'b0 : (commit_pending | commit);
            swapped        <= swap;
        end
    end

endmodule

// File: doc/game_state_bank.md
Name: game_state_bank

Overview:
- Parametrised, double-buffered game-state store for the colour-bounce game. It sits between the game-logic FSM (the writer) and the VGA draw/erase path (the reader).
- Game logic updates a shadow copy with per-field write enables. The draw path sees only the active copy, which changes atomically at frame boundaries after a commit request.
- Adds saturating score accumulation, persistent high score, and soft restart.

Parameters:
NUM_PLATS, 4, number of platforms
COLOR_W, 3, colour width per object
POS_W, 7, position width per platform
BALL_W, 8, ball position width
SCORE_W, 12, score width
BALL_COLOR_INIT, 3'b111, ball colour after reset/restart
PLAT_COLOR_INIT, 12'b001110111101, packed platform colours after reset/restart (NUM_PLATS*COLOR_W bits; platform i at bits [i*COLOR_W +: COLOR_W])

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
restart  in  1  soft game restart; high score preserved
wr_ball  in  1  write ball_in to shadow ball position
ball_in  in  BALL_W  new ball position
wr_ball_color  in  1  write ball_color_in to shadow
ball_color_in  in  COLOR_W  new ball colour
wr_plat  in  NUM_PLATS  per-platform write enable (colour and position)
plat_color_in  in  NUM_PLATS*COLOR_W  packed platform colours
plat_pos_in  in  NUM_PLATS*POS_W  packed platform positions
score_add  in  1  add score_amt to shadow score
score_amt  in  4  increment amount
commit  in  1  request shadow-to-active transfer
frame_tick  in  1  one-cycle frame-boundary strobe
prev_ball_out  out  BALL_W  active ball position of previous frame
curr_ball_out  out  BALL_W  active ball position
ball_color_out  out  COLOR_W  active ball colour
plat_color_out  out  NUM_PLATS*COLOR_W  active platform colours
plat_pos_out  out  NUM_PLATS*POS_W  active platform positions
score_out  out  SCORE_W  active score
high_score_out  out  SCORE_W  highest committed score
commit_pending  out  1  commit requested, not yet swapped
swapped  out  1  one-cycle pulse on the cycle after a swap

Behaviour:
- All state is in registers updated on posedge clk. All outputs are registered.
- Reset values:
  - Shadow and active ball position: 0; prev_ball_out: 0.
  - Ball colour: BALL_COLOR_INIT; platform colours: PLAT_COLOR_INIT; platform positions: 0.
  - Shadow and active score: 0; high_score_out: 0.
  - commit_pending: 0; swapped: 0.
- Priority: reset > restart > normal operation.
- Restart, effective in one cycle:
  - prev_ball_out <= curr_ball_out.
  - Shadow and active curr ball <= 0.
  - Ball colour <= BALL_COLOR_INIT; platform colours <= PLAT_COLOR_INIT.
  - Platform positions (shadow and active) <= plat_pos_in.
  - Scores <= 0; commit_pending <= 0; swapped <= 0.
  - high_score_out is unchanged.
- Shadow writes:
  - A field with its enable high loads on the next edge. wr_plat[i] updates only platform i's colour and position slices.
  - Score: if score_add, shadow_score <= min(shadow_score + score_amt, 2^SCORE_W-1). The add is done at SCORE_W+1 bits and saturates; it never wraps.
- Commit:
  - commit sets commit_pending. Further commits while pending have no additional effect.
  - A swap occurs on a clock edge where frame_tick=1 and (commit_pending=1 or commit=1). A commit arriving on the tick cycle itself swaps on that tick.
  - frame_tick without a commit leaves the active copy unchanged.
- Swap, single edge:
  - Active fields <= shadow values as registered before this edge. Shadow writes in the same cycle land in shadow only and appear at the next swap.
  - prev_ball_out <= curr_ball_out (the old active value); curr_ball_out <= shadow ball.
  - high_score_out <= max(high_score_out, shadow score).
  - commit_pending <= 0; swapped <= 1 for exactly one cycle.
- Active outputs never change except on swap, restart or reset. This guarantees tear-free drawing.
- Latency:
  - Shadow write to visible output: one edge to reach shadow, then the next qualifying frame_tick.
  - commit on the same cycle as frame_tick: outputs valid on the following cycle.

Test Plan:
- Reset: assert reset 1 cycle -> ball_color_out=3'b111, plat_color_out=12'b001110111101, all positions, scores and high_score_out = 0, commit_pending=0.
- Buffered update: wr_ball with ball_in=8'h2A, commit, no tick for 10 cycles -> curr_ball_out stays 0 and commit_pending=1. Pulse frame_tick -> curr_ball_out=8'h2A, prev_ball_out=0, swapped pulses one cycle, commit_pending=0.
- Per-platform write: wr_plat=4'b0100, plat_color_in all 3'b010, plat_pos_in all 7'd55, commit+tick same cycle -> only platform 2 slice changes to colour 3'b010, position 55; others unchanged.
- Score saturation: preload shadow score 4093 via repeated adds, add score_amt=9, commit+tick -> score_out=4095; high_score_out=4095.
- Restart keeps high score: after the previous case, assert restart with plat_pos_in=28'h1234567 -> score_out=0, high_score_out=4095, curr_ball_out=0, prev_ball_out=the old curr value, plat_pos_out=28'h1234567.
- Collisions: shadow write of ball 8'h10 on the same cycle as a qualifying frame_tick -> swap shows the older shadow value; 8'h10 appears at the next commit+tick. restart on the same cycle as frame_tick+commit -> restart wins, swapped=0.
